// File: rtl/lv_owt_tx_arb.sv
// -----------------------------------------------------------------------------
// lv_owt_tx_arb
//
// Arbiter and sequencer for the LV-side one-wire (OWT) transmit channel.
// Three requesters share the serializer: the watchdog ADC refresh, SPI
// register-forward frames and FSM status frames. One winner is granted at a
// time. Its frame is presented to the serializer, and the grant is held until
// the serializer reports the end of the frame or the transmit timer expires.
// The winner then receives a one-cycle ack.
//
// State table
//   state        | meaning
//   -------------+------------------------------------------------------------
//   ST_IDLE      | waiting for a request; data/src hold the last frame
//   ST_LOAD      | frame presented (vld=1), waiting for serializer rdy
//   ST_WAIT_DONE | frame accepted, waiting for the done pulse
//   ST_ACK       | one-cycle ack to the winner (+ tmo_err when timed out)
//
// Ports
//   i_clk, i_rst_n           core clock, async active-low reset
//   i_owt_en                 channel enable; low forces IDLE
//   i_wdg_adc_req / o_wdg_adc_ack   watchdog request (level) / ack pulse
//   i_spi_tx_req, i_spi_tx_data / o_spi_tx_ack   SPI forward request
//   i_fsm_tx_req, i_fsm_tx_data / o_fsm_tx_ack   FSM status request
//   o_owt_tx_vld, o_owt_tx_data, o_owt_tx_src    frame to the serializer
//   i_owt_tx_rdy             serializer accepts on vld & rdy
//   i_owt_tx_done            end-of-frame pulse from the serializer
//   o_owt_tx_tmo_err         one-cycle pulse when a frame timed out
// -----------------------------------------------------------------------------
module lv_owt_tx_arb #(
  parameter int                  REG_AW      = 8,
  parameter int                  REG_DW      = 8,
  parameter logic [2*REG_DW-1:0] WDG_ADC_CMD = 16'hA5C3,
  parameter int                  TX_TMO_CYC  = 4096,
  parameter int                  END_OF_LIST = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_owt_en,

  input  logic                i_wdg_adc_req,
  output logic                o_wdg_adc_ack,

  input  logic                i_spi_tx_req,
  input  logic [2*REG_DW-1:0] i_spi_tx_data,
  output logic                o_spi_tx_ack,

  input  logic                i_fsm_tx_req,
  input  logic [2*REG_DW-1:0] i_fsm_tx_data,
  output logic                o_fsm_tx_ack,

  output logic                o_owt_tx_vld,
  output logic [2*REG_DW-1:0] o_owt_tx_data,
  output logic [1:0]          o_owt_tx_src,
  input  logic                i_owt_tx_rdy,
  input  logic                i_owt_tx_done,
  output logic                o_owt_tx_tmo_err
);

  localparam int FW    = 2 * REG_DW;
  localparam int CNT_W = (TX_TMO_CYC > 2) ? $clog2(TX_TMO_CYC) : 1;

  // The timer is a down-counter loaded on entry to LOAD; reaching zero marks
  // the last cycle before the timeout, TX_TMO_CYC-1 cycles after the load.
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TX_TMO_CYC - 1);

  localparam logic [1:0] SRC_WDG = 2'd0;
  localparam logic [1:0] SRC_SPI = 2'd1;
  localparam logic [1:0] SRC_FSM = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ACK       = 2'd3
  } state_t;

  state_t           state;
  logic             rr_last;     // 0: spi granted last, 1: fsm granted last
  logic [CNT_W-1:0] tmo_cnt;

  logic             any_req;
  logic [1:0]       grant_src;
  logic [FW-1:0]    grant_data;
  logic             tmo_hit;

  // Parameters kept for interface compatibility; not used by the logic.
  logic unused_params;
  assign unused_params = (REG_AW != 0) ^ (END_OF_LIST != 0);

  assign any_req = i_wdg_adc_req | i_spi_tx_req | i_fsm_tx_req;
  assign tmo_hit = (tmo_cnt == '0);

  // Watchdog has strict priority; spi and fsm alternate on a tie, spi wins a
  // tie when fsm was the last of the two to be granted.
  always_comb begin
    grant_src  = SRC_WDG;
    grant_data = WDG_ADC_CMD;
    if (i_wdg_adc_req) begin
      grant_src  = SRC_WDG;
      grant_data = WDG_ADC_CMD;
    end else if (i_spi_tx_req && (!i_fsm_tx_req || rr_last)) begin
      grant_src  = SRC_SPI;
      grant_data = i_spi_tx_data;
    end else if (i_fsm_tx_req) begin
      grant_src  = SRC_FSM;
      grant_data = i_fsm_tx_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      rr_last          <= 1'b1;
      tmo_cnt          <= '0;
      o_owt_tx_vld     <= 1'b0;
      o_owt_tx_data    <= '0;
      o_owt_tx_src     <= SRC_WDG;
      o_wdg_adc_ack    <= 1'b0;
      o_spi_tx_ack     <= 1'b0;
      o_fsm_tx_ack     <= 1'b0;
      o_owt_tx_tmo_err <= 1'b0;
    end else begin
      // Pulses default low; they are raised only on entry to ACK.
      o_wdg_adc_ack    <= 1'b0;
      o_spi_tx_ack     <= 1'b0;
      o_fsm_tx_ack     <= 1'b0;
      o_owt_tx_tmo_err <= 1'b0;

      if (!i_owt_en) begin
        state        <= ST_IDLE;
        o_owt_tx_vld <= 1'b0;
        tmo_cnt      <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (any_req) begin
              state         <= ST_LOAD;
              o_owt_tx_vld  <= 1'b1;
              o_owt_tx_data <= grant_data;
              o_owt_tx_src  <= grant_src;
              tmo_cnt       <= TMO_LOAD;
              if (grant_src != SRC_WDG) begin
                rr_last <= (grant_src == SRC_FSM);
              end
            end
          end

          // done is not meaningful before the frame was accepted.
          ST_LOAD: begin
            if (tmo_hit) begin
              state            <= ST_ACK;
              o_owt_tx_vld     <= 1'b0;
              o_owt_tx_tmo_err <= 1'b1;
              o_wdg_adc_ack    <= (o_owt_tx_src == SRC_WDG);
              o_spi_tx_ack     <= (o_owt_tx_src == SRC_SPI);
              o_fsm_tx_ack     <= (o_owt_tx_src == SRC_FSM);
            end else begin
              tmo_cnt <= tmo_cnt - 1'b1;
              if (i_owt_tx_rdy) begin
                state        <= ST_WAIT_DONE;
                o_owt_tx_vld <= 1'b0;
              end
            end
          end

          // done takes precedence over a timeout landing in the same cycle.
          ST_WAIT_DONE: begin
            if (i_owt_tx_done || tmo_hit) begin
              state            <= ST_ACK;
              o_owt_tx_tmo_err <= !i_owt_tx_done;
              o_wdg_adc_ack    <= (o_owt_tx_src == SRC_WDG);
              o_spi_tx_ack     <= (o_owt_tx_src == SRC_SPI);
              o_fsm_tx_ack     <= (o_owt_tx_src == SRC_FSM);
            end else begin
              tmo_cnt <= tmo_cnt - 1'b1;
            end
          end

          ST_ACK: begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
          end

          default: begin
            state        <= ST_IDLE;
            o_owt_tx_vld <= 1'b0;
            tmo_cnt      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lv_owt_tx_arb.sv
module tb_lv_owt_tx_arb;

  localparam int          REG_DW  = 8;
  localparam int          DW      = 2 * REG_DW;
  localparam int          TMO     = 16;
  localparam logic [15:0] WDG_CMD = 16'hA5C3;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          en       = 1'b0;
  logic          wdg_req  = 1'b0;
  logic          spi_req  = 1'b0;
  logic          fsm_req  = 1'b0;
  logic [DW-1:0] spi_data = '0;
  logic [DW-1:0] fsm_data = '0;
  logic          rdy      = 1'b0;
  logic          done     = 1'b0;

  logic          wdg_ack, spi_ack, fsm_ack;
  logic          vld, tmo_err;
  logic [DW-1:0] tx_data;
  logic [1:0]    tx_src;

  int n_chk = 0;
  int n_err = 0;

  // Reference round-robin pointer: 1 = fsm was the last of spi/fsm granted.
  bit rr_last_m = 1'b1;

  always #5 clk = ~clk;

  lv_owt_tx_arb #(
    .REG_AW     (8),
    .REG_DW     (REG_DW),
    .WDG_ADC_CMD(WDG_CMD),
    .TX_TMO_CYC (TMO),
    .END_OF_LIST(1)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_owt_en        (en),
    .i_wdg_adc_req   (wdg_req),
    .o_wdg_adc_ack   (wdg_ack),
    .i_spi_tx_req    (spi_req),
    .i_spi_tx_data   (spi_data),
    .o_spi_tx_ack    (spi_ack),
    .i_fsm_tx_req    (fsm_req),
    .i_fsm_tx_data   (fsm_data),
    .o_fsm_tx_ack    (fsm_ack),
    .o_owt_tx_vld    (vld),
    .o_owt_tx_data   (tx_data),
    .o_owt_tx_src    (tx_src),
    .i_owt_tx_rdy    (rdy),
    .i_owt_tx_done   (done),
    .o_owt_tx_tmo_err(tmo_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One complete frame, started at the falling edge of an IDLE cycle.
  // a_dly: cycles after vld until rdy; d_dly: cycles after acceptance until
  // done; no_done: never send done; spur: also pulse done while in LOAD.
  task automatic run_frame(input bit w, input bit s, input bit f,
                           input int a_dly, input int d_dly,
                           input bit no_done, input bit spur);
    int            win;
    int            d;
    int            ack_c;
    bit            use_done;
    bit            tmo;
    logic [DW-1:0] exp_d;
    logic [4:0]    exp_v;

    if (w)                        win = 0;
    else if (s && (!f || rr_last_m)) win = 1;
    else                          win = 2;
    if (win != 0) rr_last_m = (win == 2);

    wdg_req = w;
    spi_req = s;
    fsm_req = f;
    if (s) spi_data = DW'($urandom);
    if (f) fsm_data = DW'($urandom);
    exp_d = (win == 0) ? WDG_CMD : (win == 1) ? spi_data : fsm_data;

    d        = a_dly + 1 + d_dly;
    use_done = !no_done && (d <= TMO - 1);
    ack_c    = use_done ? d + 1 : TMO;
    tmo      = !use_done;

    @(negedge clk);
    for (int c = 0; c <= ack_c; c++) begin
      exp_v = {c <= a_dly, (c == ack_c) && (win == 0), (c == ack_c) && (win == 1),
               (c == ack_c) && (win == 2), (c == ack_c) && tmo};
      chk("pulses", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, exp_v);
      if (c == 0) begin
        chk("src", tx_src, win);
        chk("data", tx_data, exp_d);
      end
      rdy  = (c == a_dly);
      done = (use_done && c == d) || (spur && c <= a_dly);
      if (c == ack_c) begin
        case (win)
          0:       wdg_req = 1'b0;
          1:       spi_req = 1'b0;
          default: fsm_req = 1'b0;
        endcase
        rdy  = 1'b0;
        done = 1'b0;
      end
      @(negedge clk);
    end
    chk("idle_pulses", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 0);
    chk("hold_data", tx_data, exp_d);
    chk("hold_src", tx_src, win);
  endtask

  task automatic gap(input int n);
    wdg_req = 1'b0;
    spi_req = 1'b0;
    fsm_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("gap_pulses", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 0);
    end
  endtask

  initial begin
    bit w, s, f;

    @(negedge clk);
    chk("rst_pulses", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_src", tx_src, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);

    // single watchdog frame
    run_frame(1, 0, 0, 2, 9, 0, 0);

    // three-way contention, then a spi/fsm tie after fsm was last
    run_frame(1, 1, 1, 0, 0, 0, 0);
    run_frame(0, 1, 1, 0, 0, 0, 0);
    run_frame(0, 0, 1, 1, 1, 0, 0);
    run_frame(0, 1, 1, 0, 0, 0, 0);
    run_frame(0, 1, 1, 0, 0, 0, 0);

    // continuous spi+fsm with a watchdog frame inserted mid-sequence
    for (int i = 0; i < 6; i++) begin
      if (i == 3) run_frame(1, 1, 1, 1, 0, 0, 0);
      run_frame(0, 1, 1, 0, 1, 0, 0);
    end

    // timeout, done exactly at the last counter value, spurious done in LOAD
    run_frame(0, 1, 0, 2, 0, 1, 0);
    run_frame(0, 0, 1, 2, TMO - 4, 0, 0);
    run_frame(1, 0, 0, 4, 0, 1, 1);
    run_frame(0, 1, 1, 0, 2, 0, 1);

    // channel disable while WAIT_DONE, then again in LOAD
    wdg_req  = 1'b0;
    fsm_req  = 1'b0;
    spi_req  = 1'b1;
    spi_data = DW'($urandom);
    rr_last_m = 1'b0;
    @(negedge clk);
    chk("en_load", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 5'b10000);
    rdy = 1'b1;
    @(negedge clk);
    chk("en_wait", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 0);
    rdy  = 1'b0;
    en   = 1'b0;
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_off", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 0);
      done = 1'b0;
    end
    en = 1'b1;
    @(negedge clk);
    chk("en_regrant", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 5'b10000);
    chk("en_regrant_src", tx_src, 1);
    rr_last_m = 1'b0;
    en      = 1'b0;
    spi_req = 1'b0;
    @(negedge clk);
    chk("en_off_load", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 0);
    en = 1'b1;
    @(negedge clk);
    chk("en_back", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 0);

    // reset pulse in LOAD; the round-robin pointer returns to its reset value
    fsm_req  = 1'b1;
    fsm_data = DW'($urandom);
    @(negedge clk);
    chk("rst2_load", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 5'b10000);
    chk("rst2_src", tx_src, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_pulses", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 0);
    chk("rst2_data", tx_data, 0);
    chk("rst2_src0", tx_src, 0);
    rr_last_m = 1'b1;
    fsm_req   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_idle", {vld, wdg_ack, spi_ack, fsm_ack, tmo_err}, 0);
    run_frame(0, 1, 1, 0, 0, 0, 0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      w = ($urandom_range(0, 3) == 0);
      s = $urandom_range(0, 1) != 0;
      f = $urandom_range(0, 1) != 0;
      if (!w && !s && !f) s = 1'b1;
      run_frame(w, s, f, $urandom_range(0, 4), $urandom_range(0, 14),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      gap($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
